expmod_frame_rx: RTL

EXPMOD_FRAME_RX -- requirements
Module: expmod_frame_rx

---
 rtl/expmod_pkg.sv | 24 ++
 rtl/frame_timeout.sv | 41 ++++
 rtl/expmod_frame_rx.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/expmod_pkg.sv
// Shared types and constants for the exponent/modulus frame receiver.
package expmod_pkg;

  // Receiver states; CHECK is only reachable when the checksum build option is enabled.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    VALUE = 3'd1,
    EXP   = 3'd2,
    MOD   = 3'd3,
    CHECK = 3'd4,
    ISSUE = 3'd5
  } frame_state_e;

  // Last-error code reported on err_code_out.
  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_CHECKSUM = 2'd1,
    ERR_TIMEOUT  = 2'd2,
    ERR_ZERO_MOD = 2'd3
  } frame_err_e;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/frame_timeout.sv
// Inter-byte gap counter. Counts enabled cycles without a clear; expired_out is
// high in the cycle that would complete TIMEOUT_CYCLES idle cycles, so a clear
// (byte arrival) in that same cycle suppresses it.
module frame_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic clear_in,
  input  logic enable_in,
  output logic expired_out
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] count_q, count_d;

  // Next count: restart on clear or when disabled, otherwise saturating increment.
  always_comb begin
    count_d = count_q;
    if (clear_in || !enable_in) begin
      count_d = '0;
    end else if (count_q != CNT_W'(TIMEOUT_CYCLES)) begin
      count_d = count_q + CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_out = enable_in && !clear_in && (count_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/expmod_frame_rx.sv
// Frame receiver feeding exponent_modulus: SYNC, value, exponent, modulus
// (WIDTH/8 bytes each, MSB first), optional XOR checksum byte.
// Build option: EXPMOD_FRAME_CHECKSUM_EN adds the checksum byte and CHECK state.
// A completed frame with busy_in=0 issues in the completion cycle itself, so
// ready_out follows the final byte by one cycle; with busy_in=1 it waits in ISSUE.
module expmod_frame_rx
  import expmod_pkg::*;
#(
  parameter int unsigned WIDTH          = 16,
  parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             new_data_in,
  input  logic [7:0]       data_byte_in,
  input  logic             busy_in,
  output logic             ready_out,
  output logic [WIDTH-1:0] value_out,
  output logic [WIDTH-1:0] exponent_out,
  output logic [WIDTH-1:0] modulus_out,
  output logic             frame_err_out,
  output logic [1:0]       err_code_out
);

  localparam int unsigned NB    = WIDTH / 8;
  localparam int unsigned CNT_W = (NB > 1) ? $clog2(NB) : 1;

  frame_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] val_stage_q, val_stage_d, exp_stage_q, exp_stage_d, mod_stage_q, mod_stage_d;
  logic [WIDTH-1:0] val_out_q, val_out_d, exp_out_q, exp_out_d, mod_out_q, mod_out_d;
  logic             ready_q, ready_d, ferr_q, ferr_d;
  frame_err_e       err_q, err_d;
`ifdef EXPMOD_FRAME_CHECKSUM_EN
  logic [7:0]       csum_q, csum_d;
`endif

  logic             active_s, expired_s, last_byte_s;
  logic             complete_s, issue_s, reject_s;
  frame_err_e       reject_code_s;
  logic [WIDTH-1:0] byte_ext_s, mod_final_s;

  assign active_s    = (state_q == VALUE) || (state_q == EXP) || (state_q == MOD) || (state_q == CHECK);
  assign last_byte_s = (cnt_q == CNT_W'(NB - 1));
  assign byte_ext_s  = WIDTH'(data_byte_in);

  frame_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .clear_in    (new_data_in),
    .enable_in   (active_s),
    .expired_out (expired_s)
  );

  // Next-state, staging and output logic for the frame parser.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    val_stage_d   = val_stage_q;
    exp_stage_d   = exp_stage_q;
    mod_stage_d   = mod_stage_q;
    val_out_d     = val_out_q;
    exp_out_d     = exp_out_q;
    mod_out_d     = mod_out_q;
    ready_d       = 1'b0;
    ferr_d        = 1'b0;
    err_d         = err_q;
    complete_s    = 1'b0;
    issue_s       = 1'b0;
    reject_s      = 1'b0;
    reject_code_s = ERR_NONE;
    mod_final_s   = mod_stage_q;
`ifdef EXPMOD_FRAME_CHECKSUM_EN
    csum_d        = csum_q;
    if (new_data_in && active_s && (state_q != CHECK)) begin
      csum_d = csum_q ^ data_byte_in;
    end else begin
      csum_d = csum_q;
    end
`endif

    case (state_q)
      IDLE: begin
        if (new_data_in && (data_byte_in == SYNC_BYTE)) begin
          state_d = VALUE;
          cnt_d   = '0;
`ifdef EXPMOD_FRAME_CHECKSUM_EN
          csum_d  = 8'h00;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      VALUE: begin
        if (new_data_in) begin
          val_stage_d = (val_stage_q << 4'd8) | byte_ext_s;
          cnt_d       = last_byte_s ? '0 : cnt_q + CNT_W'(1);
          state_d     = last_byte_s ? EXP : VALUE;
        end else if (expired_s) begin
          reject_s      = 1'b1;
          reject_code_s = ERR_TIMEOUT;
        end else begin
          state_d = VALUE;
        end
      end
      EXP: begin
        if (new_data_in) begin
          exp_stage_d = (exp_stage_q << 4'd8) | byte_ext_s;
          cnt_d       = last_byte_s ? '0 : cnt_q + CNT_W'(1);
          state_d     = last_byte_s ? MOD : EXP;
        end else if (expired_s) begin
          reject_s      = 1'b1;
          reject_code_s = ERR_TIMEOUT;
        end else begin
          state_d = EXP;
        end
      end
      MOD: begin
        if (new_data_in) begin
          mod_stage_d = (mod_stage_q << 4'd8) | byte_ext_s;
          cnt_d       = last_byte_s ? '0 : cnt_q + CNT_W'(1);
          if (last_byte_s) begin
`ifdef EXPMOD_FRAME_CHECKSUM_EN
            state_d = CHECK;
`else
            complete_s  = 1'b1;
            mod_final_s = mod_stage_d;
`endif
          end else begin
            state_d = MOD;
          end
        end else if (expired_s) begin
          reject_s      = 1'b1;
          reject_code_s = ERR_TIMEOUT;
        end else begin
          state_d = MOD;
        end
      end
`ifdef EXPMOD_FRAME_CHECKSUM_EN
      CHECK: begin
        if (new_data_in) begin
          if (data_byte_in == csum_q) begin
            complete_s = 1'b1;
          end else begin
            reject_s      = 1'b1;
            reject_code_s = ERR_CHECKSUM;
          end
        end else if (expired_s) begin
          reject_s      = 1'b1;
          reject_code_s = ERR_TIMEOUT;
        end else begin
          state_d = CHECK;
        end
      end
`endif
      ISSUE: begin
        if (!busy_in) begin
          issue_s = 1'b1;
        end else begin
          state_d = ISSUE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A completed frame is screened for a zero modulus before it may issue.
    if (complete_s) begin
      if (mod_final_s == '0) begin
        reject_s      = 1'b1;
        reject_code_s = ERR_ZERO_MOD;
      end else if (!busy_in) begin
        issue_s = 1'b1;
      end else begin
        state_d = ISSUE;
      end
    end else begin
      state_d = state_d;
    end

    if (issue_s) begin
      ready_d   = 1'b1;
      val_out_d = val_stage_q;
      exp_out_d = exp_stage_q;
      mod_out_d = mod_final_s;
      err_d     = ERR_NONE;
      state_d   = IDLE;
    end else if (reject_s) begin
      ferr_d  = 1'b1;
      err_d   = reject_code_s;
      state_d = IDLE;
    end else begin
      ready_d = 1'b0;
    end
  end

  // State, staging and output registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      val_stage_q <= '0;
      exp_stage_q <= '0;
      mod_stage_q <= '0;
      val_out_q   <= '0;
      exp_out_q   <= '0;
      mod_out_q   <= '0;
      ready_q     <= 1'b0;
      ferr_q      <= 1'b0;
      err_q       <= ERR_NONE;
`ifdef EXPMOD_FRAME_CHECKSUM_EN
      csum_q      <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      val_stage_q <= val_stage_d;
      exp_stage_q <= exp_stage_d;
      mod_stage_q <= mod_stage_d;
      val_out_q   <= val_out_d;
      exp_out_q   <= exp_out_d;
      mod_out_q   <= mod_out_d;
      ready_q     <= ready_d;
      ferr_q      <= ferr_d;
      err_q       <= err_d;
`ifdef EXPMOD_FRAME_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign ready_out     = ready_q;
  assign value_out     = val_out_q;
  assign exponent_out  = exp_out_q;
  assign modulus_out   = mod_out_q;
  assign frame_err_out = ferr_q;
  assign err_code_out  = err_q;

endmodule
